// File: rtl/appmul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// | appmul_seq_ctrl: row-serial approximate multiplier with exact recovery   |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module appmul_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_rec,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           out_err_nz,
  output logic           out_exact,
  output logic           busy
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int P  = 2 * W;
  localparam logic [KW-1:0] C_K_LAST = KW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RECOVER = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_rec;
  logic [KW-1:0] r_k;
  logic [P-1:0]  r_acc;
  logic [P-1:0]  r_err;

  logic [P-1:0]  w_pp;
  logic [P-1:0]  w_x;
  logic [P-1:0]  w_y;
  logic          w_last;
  logic          w_accept;

  // Current partial-product row and the carry-free approximate add terms
  assign w_pp   = r_b[r_k] ? ({{W{1'b0}}, r_a} << r_k) : '0;
  assign w_x    = r_acc ^ w_pp;
  assign w_y    = (r_acc & w_pp) << 1;
  assign w_last = (r_k == C_K_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_last) begin
          w_state_nxt = r_rec ? S_RECOVER : S_DONE;
        end
      end
      S_RECOVER: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_a   <= '0;
      r_b   <= '0;
      r_rec <= 1'b0;
      r_k   <= '0;
      r_acc <= '0;
      r_err <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_rec <= in_rec;
            r_k   <= '0;
            r_acc <= '0;
            r_err <= '0;
          end
        end
        S_COMPUTE: begin
          r_acc <= w_x | w_y;
          r_err <= r_err + (w_x & w_y);
          r_k   <= w_last ? '0 : r_k + 1'b1;
        end
        S_RECOVER: begin
          // Folding the dropped carries back in yields the exact product
          r_acc <= r_acc + r_err;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_p      = r_acc;
  assign out_err_nz = |r_err;
  assign out_exact  = r_rec;

endmodule

`default_nettype wire

// File: tb/tb_appmul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// | tb_appmul_seq_ctrl: self-checking bench for appmul_seq_ctrl              |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_appmul_seq_ctrl;

  localparam int W = 8;
  localparam int P = 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_rec = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [P-1:0] out_p;
  logic         out_err_nz;
  logic         out_exact;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [P-1:0] p;
    logic         nz;
    logic         ex;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rec;
    logic [P-1:0] p;
    logic         nz;
  } vec_t;

  exp_t sb_q[$];

  appmul_seq_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rec     (in_rec),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_err_nz (out_err_nz),
    .out_exact  (out_exact),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the carry-free row chain and its exact error sum
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [P-1:0] p, output logic [P-1:0] e);
    logic [P-1:0] acc, pp, x, y;
    acc = '0;
    e   = '0;
    for (int k = 0; k < W; k++) begin
      pp  = b[k] ? (P'(a) << k) : '0;
      x   = acc ^ pp;
      y   = (acc & pp) << 1;
      acc = x | y;
      e   = e + (x & y);
    end
    p = acc;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic rec,
                        input logic [P-1:0] ep, input logic enz);
    exp_t x;
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_a = a; in_b = b; in_rec = rec; in_valid = 1'b1;
    x.p = ep; x.nz = enz; x.ex = rec;
    sb_q.push_back(x);
    tick();
    in_valid = 1'b0;
  endtask

  // Cycle index counts the accept cycle as 0
  task automatic wait_valid(input int exp_lat);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end else begin
      chk("latency", 64'(n), 64'(exp_lat));
    end
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      x = sb_q.pop_front();
      chk("out_p", 64'(out_p), 64'(x.p));
      chk("out_err_nz", 64'(out_err_nz), 64'(x.nz));
      chk("out_exact", 64'(out_exact), 64'(x.ex));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t vt[8];
    logic [P-1:0] mp, me, prod;
    logic [W-1:0] ra, rb;
    logic         rr;

    vt[0] = '{8'd3,   8'd3,   1'b0, 16'd5,   1'b1};
    vt[1] = '{8'd3,   8'd3,   1'b1, 16'd9,   1'b1};
    vt[2] = '{8'd5,   8'd10,  1'b0, 16'd50,  1'b0};
    vt[3] = '{8'hFF,  8'h01,  1'b0, 16'd255, 1'b0};
    vt[4] = '{8'd1,   8'hFF,  1'b0, 16'd255, 1'b0};
    vt[5] = '{8'd0,   8'd0,   1'b1, 16'd0,   1'b0};
    vt[6] = '{8'hFF,  8'd0,   1'b1, 16'd0,   1'b0};
    vt[7] = '{8'd5,   8'd10,  1'b1, 16'd50,  1'b0};

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_nz", 64'(out_err_nz), 64'd0);
    chk("rst_exact", 64'(out_exact), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      accept(vt[i].a, vt[i].b, vt[i].rec, vt[i].p, vt[i].nz);
      wait_valid(W + 1 + int'(vt[i].rec));
      pop_check();
    end

    // Backpressure with a held second request
    accept(8'd3, 8'd3, 1'b0, 16'd5, 1'b1);
    wait_valid(W + 1);
    in_a = 8'd5; in_b = 8'd10; in_rec = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_p", 64'(out_p), 64'd5);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    begin
      exp_t x;
      x = sb_q.pop_front();
      chk("bp_pop_p", 64'(out_p), 64'(x.p));
      chk("bp_pop_nz", 64'(out_err_nz), 64'(x.nz));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    begin
      exp_t x;
      x.p = 16'd50; x.nz = 1'b0; x.ex = 1'b0;
      sb_q.push_back(x);
    end
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", 64'(busy), 64'd1);
    wait_valid(W + 1);
    pop_check();

    // Flush in COMPUTE cycle 4
    accept(8'd3, 8'd3, 1'b1, 16'd0, 1'b0);
    void'(sb_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_valid", 64'(out_valid), 64'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_p", 64'(out_p), 64'd0);
    chk("fl_err_nz", 64'(out_err_nz), 64'd0);

    // Reset pulse during RECOVER
    accept(8'd3, 8'd3, 1'b1, 16'd0, 1'b0);
    void'(sb_q.pop_back());
    for (int i = 0; i < W; i++) begin
      chk("rr_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    chk("rr_in_recover", 64'(busy), 64'd1);
    chk("rr_not_done", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_in_ready", 64'(in_ready), 64'd1);
    chk("rr_out_valid", 64'(out_valid), 64'd0);
    chk("rr_out_p", 64'(out_p), 64'd0);
    chk("rr_exact", 64'(out_exact), 64'd0);

    // Flush beats a simultaneous request in IDLE
    in_a = 8'd7; in_b = 8'd7; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_busy", 64'(busy), 64'd0);
    chk("fl_idle_ready", 64'(in_ready), 64'd1);

    accept(8'd3, 8'd3, 1'b1, 16'd9, 1'b1);
    wait_valid(W + 2);
    pop_check();

    // Random operands, alternating mode
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rr = 1'(i);
      model(ra, rb, mp, me);
      prod = P'(ra) * P'(rb);
      accept(ra, rb, rr, rr ? prod : mp, |me);
      wait_valid(W + 1 + int'(rr));
      if (!rr) begin
        chk("rnd_p_plus_e", 64'(out_p + me), 64'(prod));
      end
      pop_check();
    end

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/appmul_seq_ctrl.md
# appmul_seq_ctrl

Sequential controller for the approximate multiplier with error recovery. It sequences one approximate row-adder stage over all partial-product rows of a W×W unsigned multiply, one row per cycle. It accumulates the per-step error vectors in an exact error register and, on request, applies one recovery cycle that turns the approximate product into the exact product. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- W, 8: operand width; product and all internal vectors are 2W bits

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- in_a  in  W  multiplicand
- in_b  in  W  multiplier
- in_rec  in  1  1 = exact result (recovery pass), 0 = approximate result
- flush  in  1  synchronous abort; returns to IDLE, discards the operation
- out_valid  out  1  result available (DONE state)
- out_ready  in  1  consumer accepts the result
- out_p  out  2W  product, approximate or exact per the latched in_rec
- out_err_nz  out  1  accumulated error register nonzero (approximation was lossy)
- out_exact  out  1  echo of the latched in_rec
- busy  out  1  state != IDLE

## Operation
- Approximate add of 2W-bit X and Y:
  - s = (X^Y) | ((X&Y)<<1)
  - err = (X^Y) & ((X&Y)<<1)
  - Identity: X+Y = s+err (mod 2^2W).
- Registers:
  - a_r, b_r, rec_r: latched operands and mode
  - k: row index, ceil(log2 W) bits
  - acc: 2W, approximate accumulator
  - E: 2W, exact error sum
- States:
  - IDLE: in_ready=1. On in_valid: latch operands, acc=0, E=0, k=0, go to COMPUTE.
  - COMPUTE: pp = b_r[k] ? (a_r<<k) : 0. acc <= s(acc,pp); E <= E + err(acc,pp), exact add truncated to 2W; k <= k+1. After k=W-1: go to RECOVER if rec_r, else DONE.
  - RECOVER: acc <= acc + E (exact add, 2W), then go to DONE. E is retained for out_err_nz.
  - DONE: out_valid=1, out_p=acc. On out_ready: go to IDLE.
- Invariant: acc + E = a_r × (b_r mod 2^k), for exact validation.
- A zero pp row still consumes its cycle; latency is data-independent.
- out_p, out_err_nz, and out_exact are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state=IDLE, acc=0, E=0, k=0, a_r=b_r=0, rec_r=0. Outputs at reset: in_ready=1, out_valid=0, out_p=0, out_err_nz=0, out_exact=0, busy=0.
- Cycle 0 is the accept cycle (in_valid&in_ready). Cycles 1..W are COMPUTE. Cycle W+1 is RECOVER if rec_r.
- out_valid first high in cycle W+1 (approximate) or W+2 (exact).
- Throughput: IDLE is re-entered the cycle after out_ready, so the minimum initiation interval is W+2 cycles (approximate) or W+3 (exact). There is no bypass from DONE to a new accept.
- in_valid while busy is ignored (in_ready=0); the producer holds its request.
- flush has priority over every transition except reset. At the next edge: IDLE, out_valid=0, registers cleared as at reset.
- rst_n low mid-operation: same as flush; no partial result is emitted.
- flush in IDLE together with in_valid: flush wins; the request is not accepted.
- k wraps only via the state exit; the k=W-1 step is the last row.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, out_p=0, busy=0.
- a=3, b=3, rec=0 -> out_p=5, out_err_nz=1, out_valid at cycle 9 (W=8). Same operands with rec=1 -> out_p=9 at cycle 10.
- a=5, b=10, rec=0 -> out_p=50, out_err_nz=0. a=0xFF, b=0x01 -> out_p=255, err_nz=0.
- Random 1000 operands, rec=1 -> out_p == a*b. With rec=0, out_p == bit-exact model of the s-chain; out_p + E == a*b at DONE.
- Backpressure: hold out_ready=0 for 5 cycles -> out_p stable, in_ready=0, second in_valid not accepted until the cycle after out_ready.
- flush at COMPUTE cycle 4, then rst_n pulse mid-RECOVER -> both return to IDLE next edge, out_valid never asserted, next operation a=3, b=3, rec=1 yields 9.
